// File: rtl/cache_refill_arbiter.sv
// Shares one burst-read memory port between icache and dcache line refills.
// Round-robin grant, one aligned 8-beat burst at a time, line assembled per requester.
module cache_refill_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BEAT_WIDTH  = 32,
    parameter int LINE_WIDTH  = 256,
    parameter int OFFSET_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_rd_req,
    input  logic [ADDR_WIDTH-1:0] icache_rd_addr,
    output logic                  icache_ret_valid,
    output logic [LINE_WIDTH-1:0] icache_ret_data,
    input  logic                  dcache_rd_req,
    input  logic [ADDR_WIDTH-1:0] dcache_rd_addr,
    output logic                  dcache_ret_valid,
    output logic [LINE_WIDTH-1:0] dcache_ret_data,
    output logic                  mem_ar_valid,
    input  logic                  mem_ar_ready,
    output logic [ADDR_WIDTH-1:0] mem_ar_addr,
    output logic [7:0]            mem_ar_len,
    input  logic                  mem_r_valid,
    output logic                  mem_r_ready,
    input  logic [BEAT_WIDTH-1:0] mem_r_data,
    input  logic                  mem_r_last,
    output logic                  bus_err
);

    localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH - OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;
    typedef enum logic {OWN_ICACHE, OWN_DCACHE} owner_t;

    state_t                state, state_next;
    owner_t                owner, last_grant, grant_sel;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [CNT_W-1:0]      cnt;
    logic                  beat_fire;
    logic                  len_error;
    logic [LINE_WIDTH-1:0] iline, dline;

    // On a conflict the requester that did not win last time gets the port.
    always_comb begin
        grant_any = icache_rd_req | dcache_rd_req;
        if (icache_rd_req && dcache_rd_req)
            grant_sel = (last_grant == OWN_ICACHE) ? OWN_DCACHE : OWN_ICACHE;
        else if (dcache_rd_req)
            grant_sel = OWN_DCACHE;
        else
            grant_sel = OWN_ICACHE;
        grant_addr = (grant_sel == OWN_DCACHE) ? dcache_rd_addr : icache_rd_addr;
    end

    always_comb begin
        state_next       = state;
        mem_ar_valid     = 1'b0;
        mem_r_ready      = 1'b0;
        icache_ret_valid = 1'b0;
        dcache_ret_valid = 1'b0;
        case (state)
            IDLE: if (grant_any) state_next = ADDR;
            ADDR: begin
                mem_ar_valid = 1'b1;
                if (mem_ar_ready) state_next = DATA;
            end
            DATA: begin
                mem_r_ready = 1'b1;
                if (mem_r_valid && mem_r_last) state_next = RESP;
            end
            RESP: begin
                icache_ret_valid = (owner == OWN_ICACHE);
                dcache_ret_valid = (owner == OWN_DCACHE);
                state_next       = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A burst is malformed if last lands early or the counter wraps without last.
    assign beat_fire = (state == DATA) && mem_r_valid;
    assign len_error = beat_fire && (mem_r_last ? (cnt != LAST_CNT) : (cnt == LAST_CNT));

    assign mem_ar_addr     = addr_q;
    assign mem_ar_len      = 8'(BEATS - 1);
    assign icache_ret_data = iline;
    assign dcache_ret_data = dline;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_ICACHE;
            last_grant <= OWN_ICACHE;
            addr_q     <= '0;
            cnt        <= '0;
            iline      <= '0;
            dline      <= '0;
            bus_err    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && grant_any) begin
                owner      <= grant_sel;
                last_grant <= grant_sel;
                addr_q     <= grant_addr & ALIGN_MASK;
            end
            if (beat_fire) begin
                if (owner == OWN_ICACHE)
                    iline[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH] <= mem_r_data;
                else
                    dline[BEAT_WIDTH*int'(cnt) +: BEAT_WIDTH] <= mem_r_data;
                cnt <= mem_r_last ? '0 : cnt + 1'b1;
            end
            if (len_error) bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Directed bench for cache_refill_arbiter: arbitration, bursts, stalls, short bursts, reset.
module tb_cache_refill_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_req, dc_req;
    logic [31:0]  ic_addr, dc_addr;
    logic         ic_ret, dc_ret;
    logic [255:0] ic_data, dc_data;
    logic         ar_valid, ar_ready;
    logic [31:0]  ar_addr;
    logic [7:0]   ar_len;
    logic         r_valid, r_ready, r_last;
    logic [31:0]  r_data;
    logic         bus_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] a_seen;
    int          w;
    logic        er, ir, dr;

    always #5 clk = ~clk;

    cache_refill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .icache_rd_req(ic_req), .icache_rd_addr(ic_addr),
        .icache_ret_valid(ic_ret), .icache_ret_data(ic_data),
        .dcache_rd_req(dc_req), .dcache_rd_addr(dc_addr),
        .dcache_ret_valid(dc_ret), .dcache_ret_data(dc_data),
        .mem_ar_valid(ar_valid), .mem_ar_ready(ar_ready),
        .mem_ar_addr(ar_addr), .mem_ar_len(ar_len),
        .mem_r_valid(r_valid), .mem_r_ready(r_ready),
        .mem_r_data(r_data), .mem_r_last(r_last),
        .bus_err(bus_err)
    );

    // Beats base+k, one per cycle plus 'gap' idle cycles between; returns at the negedge after the last.
    task automatic drive_beats(input logic [31:0] base, input int nbeats, input int gap,
                               output logic early_ret);
        early_ret = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            r_valid = 1'b1;
            r_data  = base + 32'(k);
            r_last  = (k == nbeats - 1);
            @(negedge clk);
            r_valid = 1'b0;
            r_last  = 1'b0;
            r_data  = '0;
            if (k != nbeats - 1) begin
                if (ic_ret || dc_ret) early_ret = 1'b1;
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    if (ic_ret || dc_ret) early_ret = 1'b1;
                end
            end
        end
    endtask

    // Waits (bounded) for the address phase, then serves the burst; expects ar_ready high.
    task automatic run_burst(input logic [31:0] base, input int nbeats, input int gap,
                             output logic [31:0] addr_seen, output int ar_wait,
                             output logic early_ret, output logic i_ret, output logic d_ret);
        logic early_b;
        ar_wait   = 0;
        early_ret = 1'b0;
        addr_seen = 'x;
        while (!ar_valid && ar_wait < 30) begin
            @(negedge clk);
            ar_wait++;
            if (ic_ret || dc_ret) early_ret = 1'b1;
        end
        if (ar_valid) addr_seen = ar_addr;
        @(negedge clk);
        drive_beats(base, nbeats, gap, early_b);
        early_ret = early_ret | early_b;
        i_ret = ic_ret;
        d_ret = dc_ret;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ic_req = 0; dc_req = 0; ic_addr = 0; dc_addr = 0;
        ar_ready = 0; r_valid = 0; r_last = 0; r_data = 0;
        repeat (2) @(negedge clk);
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_ar_valid: got %b, expected 0", ar_valid); end
        checks++; if (r_ready !== 1'b0) begin errors++; $display("[TB] FAIL rst_r_ready: got %b, expected 0", r_ready); end
        checks++; if (ar_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_ar_addr: got %h, expected 0", ar_addr); end
        checks++; if (ic_ret !== 1'b0 || dc_ret !== 1'b0) begin errors++; $display("[TB] FAIL rst_ret_valid: got %b%b, expected 00", ic_ret, dc_ret); end
        checks++; if (ic_data !== 256'h0) begin errors++; $display("[TB] FAIL rst_ic_data: got %h, expected 0", ic_data); end
        checks++; if (dc_data !== 256'h0) begin errors++; $display("[TB] FAIL rst_dc_data: got %h, expected 0", dc_data); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus_err: got %b, expected 0", bus_err); end
        checks++; if (ar_len !== 8'd7) begin errors++; $display("[TB] FAIL rst_ar_len: got %0d, expected 7", ar_len); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ar_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_ar_valid: got %b, expected 0", ar_valid); end
    endtask

    task automatic test_single_icache();
        ic_addr = 32'h1C00_0044; ic_req = 1'b1; ar_ready = 1'b1;
        run_burst(32'h0, 8, 0, a_seen, w, er, ir, dr);
        ic_req = 1'b0;
        checks++; if (a_seen !== 32'h1C00_0040) begin errors++; $display("[TB] FAIL single_ar_addr: got %h, expected 1c000040", a_seen); end
        checks++; if (w !== 1) begin errors++; $display("[TB] FAIL single_ar_latency: got %0d, expected 1", w); end
        checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL single_early_ret: got %b, expected 0", er); end
        checks++; if (ir !== 1'b1) begin errors++; $display("[TB] FAIL single_ic_ret: got %b, expected 1", ir); end
        checks++; if (dr !== 1'b0) begin errors++; $display("[TB] FAIL single_dc_ret: got %b, expected 0", dr); end
        checks++; if (ic_data[31:0] !== 32'h0) begin errors++; $display("[TB] FAIL single_beat0: got %h, expected 0", ic_data[31:0]); end
        checks++; if (ic_data[255:224] !== 32'h7) begin errors++; $display("[TB] FAIL single_beat7: got %h, expected 7", ic_data[255:224]); end
        checks++; if (ic_data !== 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000) begin
            errors++; $display("[TB] FAIL single_line: got %h", ic_data); end
        @(negedge clk);
        checks++; if (ic_ret !== 1'b0 || dc_ret !== 1'b0) begin errors++; $display("[TB] FAIL single_pulse_width: got %b%b, expected 00", ic_ret, dc_ret); end
    endtask

    task automatic test_round_robin();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ic_addr = 32'h100; dc_addr = 32'h200; ic_req = 1'b1; dc_req = 1'b1;
        run_burst(32'hD0, 8, 0, a_seen, w, er, ir, dr);
        dc_req = 1'b0;
        checks++; if (a_seen !== 32'h200) begin errors++; $display("[TB] FAIL rr1_first_addr: got %h, expected 200", a_seen); end
        checks++; if (dr !== 1'b1 || ir !== 1'b0) begin errors++; $display("[TB] FAIL rr1_first_owner: got ic=%b dc=%b, expected ic=0 dc=1", ir, dr); end
        checks++; if (dc_data[31:0] !== 32'hD0 || dc_data[255:224] !== 32'hD7) begin
            errors++; $display("[TB] FAIL rr1_dc_line: got %h/%h, expected d0/d7", dc_data[31:0], dc_data[255:224]); end
        run_burst(32'hE0, 8, 0, a_seen, w, er, ir, dr);
        ic_req = 1'b0;
        checks++; if (a_seen !== 32'h100) begin errors++; $display("[TB] FAIL rr1_second_addr: got %h, expected 100", a_seen); end
        checks++; if (ir !== 1'b1 || dr !== 1'b0) begin errors++; $display("[TB] FAIL rr1_second_owner: got ic=%b dc=%b, expected ic=1 dc=0", ir, dr); end
        checks++; if (er !== 1'b0) begin errors++; $display("[TB] FAIL rr1_stray_pulse: got %b, expected 0", er); end
        checks++; if (ic_data[31:0] !== 32'hE0 || dc_data[31:0] !== 32'hD0) begin
            errors++; $display("[TB] FAIL rr1_lines: got ic=%h dc=%h, expected e0/d0", ic_data[31:0], dc_data[31:0]); end
        // A lone dcache burst leaves dcache as last winner, so the next conflict goes to icache.
        dc_addr = 32'h500; dc_req = 1'b1;
        run_burst(32'hF0, 8, 0, a_seen, w, er, ir, dr);
        dc_req = 1'b0;
        checks++; if (a_seen !== 32'h500 || dr !== 1'b1) begin errors++; $display("[TB] FAIL rr_lone_dc: got addr=%h dc=%b, expected 500/1", a_seen, dr); end
        ic_addr = 32'h300; dc_addr = 32'h400; ic_req = 1'b1; dc_req = 1'b1;
        run_burst(32'h20, 8, 0, a_seen, w, er, ir, dr);
        ic_req = 1'b0;
        checks++; if (a_seen !== 32'h300 || ir !== 1'b1 || dr !== 1'b0) begin
            errors++; $display("[TB] FAIL rr2_first: got addr=%h ic=%b dc=%b, expected 300/1/0", a_seen, ir, dr); end
        run_burst(32'h40, 8, 0, a_seen, w, er, ir, dr);
        dc_req = 1'b0;
        checks++; if (a_seen !== 32'h400 || dr !== 1'b1 || ir !== 1'b0) begin
            errors++; $display("[TB] FAIL rr2_second: got addr=%h ic=%b dc=%b, expected 400/0/1", a_seen, ir, dr); end
    endtask

    task automatic test_ar_stall();
        ar_ready = 1'b0;
        ic_addr = 32'h2000_0010; ic_req = 1'b1;
        w = 0;
        while (!ar_valid && w < 30) begin @(negedge clk); w++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ar_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_ar_valid[%0d]: got %b, expected 1", i, ar_valid); end
            checks++; if (ar_addr !== 32'h2000_0000) begin errors++; $display("[TB] FAIL stall_ar_addr[%0d]: got %h, expected 20000000", i, ar_addr); end
            checks++; if (r_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_r_ready[%0d]: got %b, expected 0", i, r_ready); end
            if (i == 2) ic_addr = 32'h3000_0000;
            @(negedge clk);
        end
        ar_ready = 1'b1;
        run_burst(32'h30, 8, 0, a_seen, w, er, ir, dr);
        ic_req = 1'b0;
        checks++; if (w !== 0 || a_seen !== 32'h2000_0000) begin errors++; $display("[TB] FAIL stall_accept: got wait=%0d addr=%h, expected 0/20000000", w, a_seen); end
        checks++; if (ir !== 1'b1) begin errors++; $display("[TB] FAIL stall_ic_ret: got %b, expected 1", ir); end
        checks++; if (ic_data !== 256'h00000037_00000036_00000035_00000034_00000033_00000032_00000031_00000030) begin
            errors++; $display("[TB] FAIL stall_line: got %h", ic_data); end
    endtask

    task automatic test_gapped_beats();
        ic_addr = 32'h40; ic_req = 1'b1;
        run_burst(32'hA0, 8, 1, a_seen, w, er, ir, dr);
        ic_req = 1'b0;
        checks++; if (ir !== 1'b1 || er !== 1'b0) begin errors++; $display("[TB] FAIL gap_ret: got ret=%b early=%b, expected 1/0", ir, er); end
        checks++; if (ic_data !== 256'h000000a7_000000a6_000000a5_000000a4_000000a3_000000a2_000000a1_000000a0) begin
            errors++; $display("[TB] FAIL gap_line: got %h", ic_data); end
        @(negedge clk);
        checks++; if (ic_ret !== 1'b0) begin errors++; $display("[TB] FAIL gap_pulse_width: got %b, expected 0", ic_ret); end
    endtask

    task automatic test_short_burst();
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL short_err_before: got %b, expected 0", bus_err); end
        ic_addr = 32'h60; ic_req = 1'b1;
        run_burst(32'h50, 6, 0, a_seen, w, er, ir, dr);
        ic_req = 1'b0;
        checks++; if (ir !== 1'b1) begin errors++; $display("[TB] FAIL short_ret: got %b, expected 1", ir); end
        checks++; if (bus_err !== 1'b1) begin errors++; $display("[TB] FAIL short_bus_err: got %b, expected 1", bus_err); end
        checks++; if (ic_data !== 256'h000000a7_000000a6_00000055_00000054_00000053_00000052_00000051_00000050) begin
            errors++; $display("[TB] FAIL short_line: got %h", ic_data); end
        @(negedge clk);
        checks++; if (ic_ret !== 1'b0) begin errors++; $display("[TB] FAIL short_pulse_width: got %b, expected 0", ic_ret); end
        repeat (3) @(negedge clk);
        checks++; if (bus_err !== 1'b1) begin errors++; $display("[TB] FAIL short_err_sticky: got %b, expected 1", bus_err); end
    endtask

    task automatic test_reset_mid_burst();
        ic_addr = 32'h700; ic_req = 1'b1;
        w = 0;
        while (!ar_valid && w < 30) begin @(negedge clk); w++; end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            r_valid = 1'b1; r_data = 32'h90 + 32'(k);
            @(negedge clk);
        end
        r_valid = 1'b1; r_data = 32'h93;
        rst_n = 1'b0;
        #1;
        checks++; if (ic_ret !== 1'b0 || dc_ret !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_ret: got %b%b, expected 00", ic_ret, dc_ret); end
        checks++; if (ic_data !== 256'h0 || dc_data !== 256'h0) begin errors++; $display("[TB] FAIL mid_rst_lines: got ic=%h dc=%h, expected 0", ic_data, dc_data); end
        checks++; if (ar_valid !== 1'b0 || r_ready !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_handshake: got ar=%b r=%b, expected 0/0", ar_valid, r_ready); end
        checks++; if (ar_addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_rst_ar_addr: got %h, expected 0", ar_addr); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_bus_err: got %b, expected 0", bus_err); end
        ic_req = 1'b0; r_valid = 1'b0; r_data = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ic_ret !== 1'b0 || dc_ret !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_stale: got %b%b, expected 00", ic_ret, dc_ret); end
        ic_addr = 32'h1C00_0044; ic_req = 1'b1;
        run_burst(32'h10, 8, 0, a_seen, w, er, ir, dr);
        ic_req = 1'b0;
        checks++; if (a_seen !== 32'h1C00_0040 || w !== 1) begin errors++; $display("[TB] FAIL post_rst_ar: got addr=%h wait=%0d, expected 1c000040/1", a_seen, w); end
        checks++; if (er !== 1'b0 || ir !== 1'b1 || dr !== 1'b0) begin
            errors++; $display("[TB] FAIL post_rst_ret: got early=%b ic=%b dc=%b, expected 0/1/0", er, ir, dr); end
        checks++; if (ic_data !== 256'h00000017_00000016_00000015_00000014_00000013_00000012_00000011_00000010) begin
            errors++; $display("[TB] FAIL post_rst_line: got %h", ic_data); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_bus_err: got %b, expected 0", bus_err); end
    endtask

    initial begin
        $display("[TB] starting cache_refill_arbiter bench");
        test_reset();
        test_single_icache();
        test_round_robin();
        test_ar_stall();
        test_gapped_beats();
        test_short_burst();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cache_refill_arbiter.md
Name: cache_refill_arbiter

Overview:
- Shares one downstream burst-read memory port between the instruction-cache and data-cache line-refill requesters.
- Each requester uses a level-held request with a 32-bit address and receives a one-cycle return pulse carrying a full 256-bit line.
- The block arbitrates between requesters, issues an aligned 8-beat burst, assembles the 32-bit beats into the line, and routes the line back to the granted requester.
- It sits between the two caches and the bus bridge.

Parameters:
- ADDR_WIDTH, 32, address width of requests and of the downstream address.
- BEAT_WIDTH, 32, downstream data beat width.
- LINE_WIDTH, 256, cache line width. BEATS = LINE_WIDTH/BEAT_WIDTH = 8.
- OFFSET_BITS, 5, log2 of the line size in bytes; used for address alignment.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- icache_rd_req  in  1  icache refill request; held high until icache_ret_valid.
- icache_rd_addr  in  32  icache refill address; stable while the request is high.
- icache_ret_valid  out  1  one-cycle pulse: icache line returned.
- icache_ret_data  out  256  icache line; beat k occupies bits [32k+31:32k].
- dcache_rd_req  in  1  dcache refill request; same rules as icache.
- dcache_rd_addr  in  32  dcache refill address.
- dcache_ret_valid  out  1  one-cycle pulse: dcache line returned.
- dcache_ret_data  out  256  dcache line.
- mem_ar_valid  out  1  downstream burst address valid.
- mem_ar_ready  in  1  downstream address accepted.
- mem_ar_addr  out  32  line-aligned burst address.
- mem_ar_len  out  8  constant BEATS-1 = 8'd7.
- mem_r_valid  in  1  read beat valid.
- mem_r_ready  out  1  read beat accepted.
- mem_r_data  in  32  read beat data.
- mem_r_last  in  1  last beat of burst.
- bus_err  out  1  sticky flag: burst length mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - FSM to IDLE; beat counter 0; last_grant = ICACHE.
  - All outputs 0, including the line registers and bus_err.
  - Reset mid-burst abandons the transfer immediately; no ret_valid pulse is issued. The downstream port is reset in the same domain.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - Samples both requests.
  - If only one is high, grant it.
  - If both are high, round-robin: grant the requester not equal to last_grant. The first conflict after reset goes to DCACHE.
  - On grant: latch owner and aligned address = {rd_addr[31:5],5'b0}; update last_grant; go to ADDR.
  - If no request is high, stay in IDLE.
- ADDR:
  - mem_ar_valid=1 with the latched address and len=7.
  - On mem_ar_valid & mem_ar_ready, go to DATA.
  - mem_ar_valid stays high until accepted; the address does not change.
- DATA:
  - mem_r_ready=1.
  - Each cycle with mem_r_valid=1, write mem_r_data into slice [32*cnt+31:32*cnt] of the owner's line register, then increment the 3-bit cnt.
  - On a beat with mem_r_last=1, go to RESP and clear cnt.
  - If mem_r_last arrives with cnt != 7, or cnt wraps 7->0 without last, set bus_err. Stay in DATA until last.
  - Slices not written keep their previous contents.
- RESP:
  - Pulse the owner's ret_valid for exactly one cycle; the other requester's ret_valid stays 0.
  - Go to IDLE.
- Latency: a request sampled in cycle t gives mem_ar_valid in t+1. With ar_ready and r_valid always high, beats arrive in t+2..t+9 and ret_valid is asserted in t+10.
- Line data: the per-requester line registers hold their value after the pulse until that requester's next burst overwrites them. The other requester's line is never touched.
- Requester rules:
  - A requester must deassert rd_req in the cycle after it sees ret_valid. The IDLE cycle following RESP samples requests again.
  - Address changes while a request is held are ignored after grant.
  - A request raised while the other requester is being served waits; there is no preemption.
- Only one burst is outstanding at a time. mem_ar_valid and mem_r_ready are never high together.

Test Plan:
- Single icache request, addr 0x1C00_0044; ar_ready=1; beats 0x0..0x7 back-to-back:
  - mem_ar_addr = 0x1C00_0040, len = 7.
  - icache_ret_valid pulses 10 cycles after the request is sampled.
  - icache_ret_data[31:0] = 0, [255:224] = 7.
  - dcache_ret_valid stays 0.
- Both requests high out of reset (icache 0x100, dcache 0x200):
  - dcache is served first (ar_addr 0x200), then icache (0x100).
  - Two separate ret pulses.
  - A second simultaneous pair is served icache first.
- ar_ready held low 5 cycles:
  - mem_ar_valid stays high and the address stays stable.
  - After acceptance, the data phase proceeds normally.
- r_valid gapped (beat every other cycle, data 0xA0+k):
  - Line assembled correctly with no extra beats consumed.
  - ret_valid in the cycle after the last beat.
- r_last asserted on the 6th beat:
  - bus_err=1 and stays 1.
  - ret_valid pulses once; slices 6..7 keep their prior values.
- rst_n asserted low during the 4th beat:
  - All outputs are 0 immediately.
  - After release, a fresh icache request completes normally and no stale ret_valid appears.
